// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART echo responder slice.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2,
        GAP    = 2'd3
    } state_e;

    localparam int unsigned PARITY_ERR = 0;
    localparam int unsigned START_ERR  = 1;
    localparam int unsigned STOP_ERR   = 2;

    // Ceiling log2, used to size pointers and counters.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned acc;
        res = 0;
        acc = 1;
        while (acc < value) begin
            acc = acc << 1;
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_echo_responder_if.sv
// Rx-complete and Tx-handshake signals between the UART units and the responder.
interface uart_echo_responder_if;
    logic       rx_done_flag;
    logic [2:0] rx_error_flag;
    logic [7:0] rx_data;
    logic       tx_active_flag;
    logic       tx_done_flag;
    logic       send;
    logic [7:0] data_in;

    modport master (
        input  rx_done_flag, rx_error_flag, rx_data, tx_active_flag, tx_done_flag,
        output send, data_in
    );

    modport slave (
        output rx_done_flag, rx_error_flag, rx_data, tx_active_flag, tx_done_flag,
        input  send, data_in
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with binary pointers and a separate occupancy counter.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [clog2(DEPTH):0]  count_o
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_wr;
    logic             do_rd;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A read in the same cycle frees a slot, so a write at full still lands.
    assign do_rd = rd_en_i & ~empty_o;
    assign do_wr = wr_en_i & (~full_o | do_rd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + CW'(1);
            end else if (!do_wr && do_rd) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_echo_responder.sv
// Far-end responder: buffers clean Rx bytes and replays them, XOR-transformed,
// through the Tx send/data_in handshake with ack timeout and inter-frame gap.
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter logic [7:0]  XOR_MASK    = 8'h00,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned ACK_TIMEOUT = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    uart_echo_responder_if.master  bus,
    output logic [clog2(DEPTH):0]  fifo_count,
    output logic [7:0]             drop_count,
    output logic                   timeout_flag,
    output logic                   busy
);

    localparam int unsigned CW = clog2(DEPTH) + 1;
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? clog2(GAP_CYCLES) : 1;

    state_e           state_q;
    logic             rx_prev_q;
    logic             frame_q;
    logic             frame_clean_q;
    logic [7:0]       frame_byte_q;
    logic             tx_done_prev_q;
    logic             tx_act_prev_q;
    logic             send_q;
    logic [7:0]       data_in_q;
    logic [7:0]       drop_q;
    logic             timeout_q;
    logic [TW-1:0]    timer_q;
    logic [GW-1:0]    gap_q;

    logic             fifo_wr;
    logic             fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [CW-1:0]    fifo_cnt;
    logic             tx_finished;

    assign fifo_rd     = (state_q == IDLE) & enable & ~fifo_empty;
    assign fifo_wr     = frame_q & frame_clean_q & enable & (~fifo_full | fifo_rd);
    assign tx_finished = (bus.tx_done_flag & ~tx_done_prev_q) |
                         (~bus.tx_active_flag & tx_act_prev_q);

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i     (clock),
        .rst_i     (reset),
        .wr_en_i   (fifo_wr),
        .wr_data_i (frame_byte_q),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt)
    );

    // Rx edge capture (cycle 0) feeding the FIFO write decision (cycle 1).
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_prev_q      <= 1'b0;
            frame_q        <= 1'b0;
            frame_clean_q  <= 1'b0;
            frame_byte_q   <= '0;
            tx_done_prev_q <= 1'b0;
            tx_act_prev_q  <= 1'b0;
            drop_q         <= '0;
        end else begin
            rx_prev_q      <= bus.rx_done_flag;
            frame_q        <= bus.rx_done_flag & ~rx_prev_q;
            frame_clean_q  <= ~(|bus.rx_error_flag);
            frame_byte_q   <= bus.rx_data ^ XOR_MASK;
            tx_done_prev_q <= bus.tx_done_flag;
            tx_act_prev_q  <= bus.tx_active_flag;
            if (frame_q && !fifo_wr && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Tx replay FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            send_q    <= 1'b0;
            data_in_q <= '0;
            timeout_q <= 1'b0;
            timer_q   <= '0;
            gap_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fifo_rd) begin
                        data_in_q <= fifo_rdata;
                        timer_q   <= '0;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.tx_active_flag) begin
                        send_q  <= 1'b0;
                        state_q <= ACTIVE;
                    end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                        send_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        gap_q     <= '0;
                        state_q   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        send_q  <= 1'b1;
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ACTIVE: begin
                    if (tx_finished) begin
                        gap_q   <= '0;
                        state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.send     = send_q;
    assign bus.data_in  = data_in_q;
    assign fifo_count   = fifo_cnt;
    assign drop_count   = drop_q;
    assign timeout_flag = timeout_q;
    assign busy         = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scenario bench for uart_echo_responder with a Tx stub and a replay scoreboard.
module tb_uart_echo_responder;

    localparam int unsigned DEPTH = 8;
    localparam logic [7:0]  MASK  = 8'h20;
    localparam int unsigned GAP   = 16;
    localparam int unsigned ACK   = 4096;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] fifo_count;
    logic [7:0] drop_count;
    logic       timeout_flag;
    logic       busy;

    uart_echo_responder_if bus();

    uart_echo_responder #(
        .DEPTH       (DEPTH),
        .XOR_MASK    (MASK),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .bus          (bus),
        .fifo_count   (fifo_count),
        .drop_count   (drop_count),
        .timeout_flag (timeout_flag),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int         n_tests;
    int         n_fail;
    int         exp_drop;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    bit         stub_auto;
    bit         stub_hold;

    // Tx stub: acknowledges send with active, optionally holds, then pulses done.
    initial begin
        bus.tx_active_flag = 1'b0;
        bus.tx_done_flag   = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (stub_auto && bus.send && !bus.tx_active_flag) begin
                obs_q.push_back(bus.data_in);
                bus.tx_active_flag = 1'b1;
                repeat (3) @(posedge clock);
                while (stub_hold) @(posedge clock);
                #1;
                bus.tx_done_flag   = 1'b1;
                bus.tx_active_flag = 1'b0;
                @(posedge clock); #1;
                bus.tx_done_flag   = 1'b0;
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic [2:0] e);
        bus.rx_data       = d;
        bus.rx_error_flag = e;
        bus.rx_done_flag  = 1'b1;
        @(posedge clock); #1;
        bus.rx_done_flag  = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clock); #1;
            if (i >= 2 && !busy && !bus.tx_active_flag && !bus.tx_done_flag) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clock); #1;
        n_tests++; if (bus.send !== 1'b0) begin n_fail++; $display("FAIL reset_send got %0b want 0", bus.send); end
        n_tests++; if (bus.data_in !== 8'h00) begin n_fail++; $display("FAIL reset_data_in got %02h want 00", bus.data_in); end
        n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
        n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
        n_tests++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %0b want 0", timeout_flag); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_single();
        int         lat;
        int         gap;
        bit         ok;
        logic [7:0] e;
        logic [7:0] o;
        stub_auto = 1'b1;
        stub_hold = 1'b0;
        exp_q.push_back(8'h41 ^ MASK);
        bus.rx_data       = 8'h41;
        bus.rx_error_flag = 3'b000;
        bus.rx_done_flag  = 1'b1;
        @(posedge clock); #1;
        bus.rx_done_flag  = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clock); #1;
            if (bus.send) begin lat = i; break; end
        end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL single_latency got %0d want 3", lat); end
        n_tests++; if (bus.data_in !== 8'h61) begin n_fail++; $display("FAIL single_data_in got %02h want 61", bus.data_in); end
        for (int i = 0; i < 20 && bus.send; i++) begin @(posedge clock); #1; end
        gap = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (!busy) begin gap = i + 1; break; end
        end
        n_tests++; if (gap < int'(GAP) || gap > int'(GAP) + 10) begin n_fail++; $display("FAIL single_gap got %0d want %0d..%0d", gap, GAP, GAP + 10); end
        wait_idle(50, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_idle got busy want idle"); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL single_sb_byte got %02h want %02h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_burst();
        bit         ok;
        logic [7:0] e;
        logic [7:0] o;
        stub_auto = 1'b1;
        stub_hold = 1'b1;
        send_frame(8'h30, 3'b000);
        exp_q.push_back(8'h30 ^ MASK);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (bus.tx_active_flag) begin ok = 1'b1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL burst_primer_active got 0 want 1"); end
        for (int i = 0; i < 10; i++) begin
            send_frame(8'h50 + 8'(i), 3'b000);
            if (i < 8) exp_q.push_back((8'h50 + 8'(i)) ^ MASK);
        end
        exp_drop += 2;
        n_tests++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL burst_fifo_count got %0d want 8", fifo_count); end
        n_tests++; if (drop_count !== 8'(exp_drop)) begin n_fail++; $display("FAIL burst_drop got %0d want %0d", drop_count, exp_drop); end
        stub_hold = 1'b0;
        wait_idle(2000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL burst_idle got busy want idle"); end
        n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL burst_empty got %0d want 0", fifo_count); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL burst_sb_byte got %02h want %02h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_errors();
        bit saw_send;
        saw_send = 1'b0;
        send_frame(8'h11, 3'b001);
        saw_send |= bus.send;
        send_frame(8'h22, 3'b100);
        exp_drop += 2;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            saw_send |= bus.send;
        end
        n_tests++; if (saw_send) begin n_fail++; $display("FAIL errors_send got 1 want 0"); end
        n_tests++; if (drop_count !== 8'(exp_drop)) begin n_fail++; $display("FAIL errors_drop got %0d want %0d", drop_count, exp_drop); end
        n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL errors_fifo_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_timeout();
        int         cyc;
        bit         ok;
        logic [7:0] e;
        logic [7:0] o;
        stub_auto = 1'b0;
        send_frame(8'h55, 3'b000);
        send_frame(8'h66, 3'b000);
        cyc = 3;
        ok  = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clock); #1;
            cyc++;
            if (timeout_flag) begin ok = 1'b1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL timeout_flag got 0 want 1"); end
        n_tests++; if (cyc < int'(ACK) || cyc > int'(ACK) + 20) begin n_fail++; $display("FAIL timeout_cycles got %0d want %0d..%0d", cyc, ACK, ACK + 20); end
        n_tests++; if (bus.send !== 1'b0) begin n_fail++; $display("FAIL timeout_send got %0b want 0", bus.send); end
        n_tests++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL timeout_queued got %0d want 1", fifo_count); end
        exp_q.push_back(8'h66 ^ MASK);
        stub_auto = 1'b1;
        wait_idle(200, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL timeout_idle got busy want idle"); end
        n_tests++; if (timeout_flag !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %0b want 1", timeout_flag); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL timeout_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL timeout_sb_byte got %02h want %02h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_full_pop();
        bit         ok;
        logic [7:0] e;
        logic [7:0] o;
        stub_auto = 1'b1;
        stub_hold = 1'b1;
        send_frame(8'h70, 3'b000);
        exp_q.push_back(8'h70 ^ MASK);
        for (int i = 0; i < 20 && !bus.tx_active_flag; i++) begin @(posedge clock); #1; end
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h80 + 8'(i), 3'b000);
            exp_q.push_back((8'h80 + 8'(i)) ^ MASK);
        end
        enable    = 1'b0;
        stub_hold = 1'b0;
        repeat (40) @(posedge clock); #1;
        n_tests++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL full_retained got %0d want 8", fifo_count); end
        n_tests++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL full_disabled_sends got %0d want 1", obs_q.size()); end
        bus.rx_data       = 8'h99;
        bus.rx_error_flag = 3'b000;
        bus.rx_done_flag  = 1'b1;
        @(posedge clock); #1;
        bus.rx_done_flag  = 1'b0;
        enable            = 1'b1;
        exp_q.push_back(8'h99 ^ MASK);
        @(posedge clock); #1;
        n_tests++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL full_pop_count got %0d want 8", fifo_count); end
        n_tests++; if (drop_count !== 8'(exp_drop)) begin n_fail++; $display("FAIL full_pop_drop got %0d want %0d", drop_count, exp_drop); end
        wait_idle(2000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL full_idle got busy want idle"); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL full_sb_byte got %02h want %02h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        bit saw_send;
        stub_auto = 1'b1;
        stub_hold = 1'b1;
        for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 3'b000);
        for (int i = 0; i < 20 && !bus.tx_active_flag; i++) begin @(posedge clock); #1; end
        n_tests++; if (fifo_count !== 4'd3) begin n_fail++; $display("FAIL rst_mid_queued got %0d want 3", fifo_count); end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_tests++; if (bus.send !== 1'b0) begin n_fail++; $display("FAIL rst_mid_send got %0b want 0", bus.send); end
        n_tests++; if (bus.data_in !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data_in got %02h want 00", bus.data_in); end
        n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_fifo_count got %0d want 0", fifo_count); end
        n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL rst_mid_drop got %0d want 0", drop_count); end
        n_tests++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL rst_mid_timeout got %0b want 0", timeout_flag); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
        stub_hold = 1'b0;
        saw_send  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            saw_send |= bus.send;
        end
        n_tests++; if (saw_send) begin n_fail++; $display("FAIL rst_mid_post_send got 1 want 0"); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_post_busy got %0b want 0", busy); end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        bus.rx_done_flag  = 1'b0;
        bus.rx_error_flag = 3'b000;
        bus.rx_data       = 8'h00;
        stub_auto = 1'b0;
        stub_hold = 1'b0;
        n_tests   = 0;
        n_fail    = 0;
        exp_drop  = 0;
        test_reset();
        test_single();
        test_burst();
        test_errors();
        test_timeout();
        test_full_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_echo_responder.md
Name: uart_echo_responder

Overview:
Far-end responder for the duplex UART user interface. It consumes completed receive frames from the Rx unit and buffers error-free bytes in an internal FIFO. It replays each byte, optionally XOR-transformed, through the Tx unit's send/data_in handshake. This closes the loop for board-level link tests and forms the base of a later command responder.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
XOR_MASK, 8'h00, XORed into each byte on replay (8'h20 toggles ASCII case)
GAP_CYCLES, 16, idle clocks enforced between consecutive Tx frames
ACK_TIMEOUT, 4096, clocks to wait for tx_active_flag after raising send

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  0: incoming frames dropped, Tx FSM finishes current frame then idles
rx_done_flag  in  1  Rx frame-complete level; rising edge = one new frame
rx_error_flag  in  3  [0] parity, [1] start, [2] stop error for the frame
rx_data  in  8  received byte, valid on rx_done_flag rising edge
tx_active_flag  in  1  Tx frame in progress
tx_done_flag  in  1  Tx frame complete
send  out  1  Tx start request
data_in  out  8  byte presented to Tx
fifo_count  out  log2(DEPTH)+1  current occupancy
drop_count  out  8  saturating count of frames dropped (error, full, or disabled)
timeout_flag  out  1  sticky; set on ACK_TIMEOUT expiry
busy  out  1  Tx FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset, synchronous on a clock edge with reset=1: send=0, data_in=0, fifo_count=0, drop_count=0, timeout_flag=0, busy=0, FIFO pointers=0, FSM=IDLE, edge-detect register=0.
- Rx capture: register rx_done_flag; new frame = rx_done_flag & ~prev.
- On a new frame:
  - Error-free (rx_error_flag==0), enable=1 and FIFO not full: write rx_data ^ XOR_MASK.
  - Otherwise: no write, drop_count+1, saturating at 255.
- FIFO: binary pointers with wrap at DEPTH, extra occupancy bit.
  - Simultaneous write and read in one cycle is legal, including at full: the read frees an entry first, so the write succeeds and the count is unchanged.
  - Read when empty never occurs; the FSM guards on count.
- Tx FSM states:
  - IDLE: if fifo_count>0 and enable, pop the head into data_in and go to REQ. The pop happens in the same cycle; data_in is registered and valid one cycle after the pop.
  - REQ: send=1. If tx_active_flag=1, set send=0 and go to ACTIVE. If the timer reaches ACK_TIMEOUT, set send=0, set timeout_flag, and go to GAP; the byte is discarded.
  - ACTIVE: wait for the tx_done_flag rising edge, or for tx_active_flag falling if done is level-held. Then go to GAP.
  - GAP: count GAP_CYCLES clocks, then go to IDLE. With GAP_CYCLES=0, go directly to IDLE.
- data_in is held stable from REQ until leaving ACTIVE.
- Latency, FIFO empty and FSM idle: the rx_done_flag edge is registered at cycle 0, the FIFO write lands at cycle 1, IDLE pops at cycle 2, and send=1 at cycle 3.
- enable=0 mid-frame: the current REQ/ACTIVE/GAP sequence completes, then the FSM stays in IDLE and the FIFO contents are retained.
- reset=1 mid-frame: everything returns to reset values next edge, and send drops immediately at that edge.
- timeout_flag is cleared only by reset.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, REQ, ACTIVE, GAP), error-bit index constants (PARITY_ERR=0, START_ERR=1, STOP_ERR=2), and the clog2 helper for counter widths.
- One sub-module, uart_sync_fifo: parameterised DEPTH×8, with wr_en/rd_en/full/empty/count.
- The FSM, edge detect and counters stay in the top.

Test Plan:
- Single byte 8'h41, XOR_MASK=8'h20: rx_done edge with error=0 -> send rises 3 cycles later with data_in=8'h61. Stub Tx raises active, then done -> send drops, GAP of 16 clocks, busy=0.
- Burst of 10 error-free bytes, DEPTH=8, Tx stub stalled -> 8 stored, drop_count=2, fifo_count=8. Release Tx -> 8 bytes replayed in order, FIFO empties.
- Frame with rx_error_flag=3'b001, then one with 3'b100 -> no send, drop_count=2, fifo_count=0.
- Tx stub never asserts active -> after 4096 clocks send=0 and timeout_flag=1. The next queued byte is still sent normally.
- FIFO full plus a new frame arriving in the same cycle the FSM pops -> byte accepted, fifo_count stays 8, drop_count unchanged.
- reset asserted during ACTIVE with 3 bytes queued -> next cycle all outputs are zero. The Tx stub's done pulse after reset produces no send.
